rf_wport_sched: RTL
===================

# rf_wport_sched

Write-port scheduler and scoreboard for the CPU's 2-read/1-write `regfile`. It shares the single write port between the in-order pipeline writeback stage and a long-latency unit (multiply/divide), whose results it buffers in a small FIFO. It also tracks which GPRs have an outstanding long-latency write, so decode can detect RAW/WAW hazards. It sits between the writeback stage, the long-latency unit and the `regfile` `we/wn/d` inputs.

## Interface
- `DEPTH`, 2: long-latency result FIFO entries; power of two, ≥2.
- `STARVE`, 8: cycles a FIFO head may wait before pipeline writeback is held; range 1–15.

- `clk` in 1: clock; all state updates on posedge.
- `clrn` in 1: asynchronous active-low reset.
- `wb_we` in 1: pipeline writeback request.
- `wb_wn` in 5: pipeline destination register.
- `wb_d` in 32: pipeline write data.
- `wb_stall` out 1: pipeline must hold writeback (`wb_we`=0) this cycle.
- `lu_valid` in 1: long-latency result valid.
- `lu_wn` in 5: long-latency destination register.
- `lu_d` in 32: long-latency data.
- `lu_ready` out 1: FIFO can accept a result.
- `iss_valid` in 1: a long-latency op is issued this cycle.
- `iss_wn` in 5: destination register of the issued op.
- `rna`, `rnb`, `rnw` in 5 each: decode source A, source B and destination register numbers.
- `haz_a`, `haz_b`, `haz_w` out 1 each: the corresponding register is busy.
- `rf_we` out 1: to regfile `we`.
- `rf_wn` out 5: to regfile `wn`.
- `rf_d` out 32: to regfile `d`.
- `idle` out 1: FIFO empty and no busy bits.

## Operation
- Pipeline request is live when `wb_we`=1 and `wb_wn`≠0. A request with `wb_wn`=0 is dropped, and the port is free that cycle.
- **Grant priority:**
  - If `wb_stall`=1 and FIFO non-empty: FIFO head is granted.
  - Else if a pipeline request is live: pipeline is granted.
  - Else if FIFO non-empty: FIFO head is granted.
  - Else: `rf_we`=0.
- **Write-port outputs:** `rf_we/rf_wn/rf_d` are combinational from the granted source. Data is written by the regfile at the same edge.
- If `wb_we`=1 while `wb_stall`=1, the request is ignored; this is a protocol violation that the bench flags.
- **FIFO:** push on `lu_valid && lu_ready`; pop when the head is granted. `lu_ready` = !full, computed from registered count. A full FIFO refuses a push even if a pop happens in the same cycle. Entries with `lu_wn`=0 are accepted and popped, but assert `rf_we`=0.
- **Age counter:** 4 bits.
  - Resets to 0 on pop or when the FIFO is empty.
  - Otherwise increments, saturating at `STARVE`.
  - `wb_stall` = (age == `STARVE`).
- **Scoreboard:** `busy[31:1]`; `busy[0]` is constant 0.
  - `iss_valid && iss_wn≠0` sets `busy[iss_wn]`.
  - A FIFO pop clears `busy[head_wn]`.
  - If set and clear hit the same register in one cycle, set wins.
  - `haz_x` = `busy[rnx]`, combinational.
  - Decode must stall on any hazard. The pipeline never writes a busy register.
- `idle` = FIFO empty && `busy`==0.

## Timing
- **Reset** (`clrn`=0, async): FIFO empty, age=0, `busy`=0. Resulting outputs: `lu_ready`=1, `wb_stall`=0, `haz_*`=0, `idle`=1. `rf_*` pass the pipeline request through (FIFO empty).
- Reset asserted mid-operation discards buffered results and busy bits immediately.
- A result accepted at edge t is written at edge t+1 at the earliest, when the port is uncontended.
- A busy bit set at edge t is visible on `haz_*` from edge t onward. It is cleared at the edge where its write commits, so a dependent read in the following cycle sees the new regfile value.
- Under continuous pipeline writes, a FIFO head is written no later than `STARVE`+1 cycles after it becomes head.
- Push into an empty FIFO plus a free port: written the next cycle, not the same cycle (no bypass).

## Test plan
- **Reset then pipeline writes:** `wb_we`=1, `wb_wn`=5, `wb_d`=0x1234 → `rf_we`=1, `rf_wn`=5, `rf_d`=0x1234 the same cycle. `wb_wn`=0 → `rf_we`=0.
- **Issue then complete:** issue to r7 → `haz_a`=1 with `rna`=7. Push {7, 0xDEAD} → next cycle `rf_we`=1, `rf_wn`=7. Following cycle `haz_a`=0 and `idle`=1.
- **Contention:** push {9, 0xAA} while `wb_we`=1 every cycle (`wb_wn`=3) → FIFO waits. After 8 cycles `wb_stall`=1. Next cycle r9 is written and `wb_stall` drops.
- **Full FIFO:** two pushes with the port blocked → `lu_ready`=0. Third `lu_valid` is held, not lost. Pop in the same cycle does not admit it; it is admitted the cycle after.
- **Same-cycle set/clear:** pop r4 while issuing to r4 → `busy[4]` stays 1.
- **Mid-operation reset:** FIFO holding 2 entries, `busy` nonzero, `clrn` pulsed low → `lu_ready`=1, `idle`=1, no stale writes afterwards.

Source files
------------

// File: rtl/rf_wport_sched.sv
// rf_wport_sched: shares the regfile write port between pipeline writeback
// and a buffered long-latency unit; tracks GPRs with pending long writes.
module rf_wport_sched #(
   parameter int DEPTH  = 2,
   parameter int STARVE = 8
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        wb_we,
   input  logic [4:0]  wb_wn,
   input  logic [31:0] wb_d,
   output logic        wb_stall,
   input  logic        lu_valid,
   input  logic [4:0]  lu_wn,
   input  logic [31:0] lu_d,
   output logic        lu_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_wn,
   input  logic [4:0]  rna,
   input  logic [4:0]  rnb,
   input  logic [4:0]  rnw,
   output logic        haz_a,
   output logic        haz_b,
   output logic        haz_w,
   output logic        rf_we,
   output logic [4:0]  rf_wn,
   output logic [31:0] rf_d,
   output logic        idle
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    fwn [DEPTH];
   logic [31:0]   fd  [DEPTH];
   logic [AW-1:0] rp, wp;
   logic [CW-1:0] cnt;
   logic [3:0]    age;
   logic [31:1]   busy;
   logic [31:1]   busy_nxt;
   logic [31:0]   busy_all;
   logic          wb_live, fempty, push, pop;
   logic [4:0]    head_wn;
   logic [31:0]   head_d;

   assign fempty   = (cnt == '0);
   assign lu_ready = (cnt != CW'(DEPTH));
   assign wb_stall = (age == 4'(STARVE));
   assign wb_live  = wb_we && (wb_wn != 5'd0);
   assign head_wn  = fwn[rp];
   assign head_d   = fd[rp];
   // Head wins when the pipeline is held off or has nothing to write.
   assign pop      = !fempty && (wb_stall || !wb_live);
   assign push     = lu_valid && lu_ready;

   // Write-port mux; r0 results still drain the FIFO but never write.
   always_comb begin
      rf_we = 1'b0;
      rf_wn = wb_wn;
      rf_d  = wb_d;
      if (pop) begin
         rf_we = (head_wn != 5'd0);
         rf_wn = head_wn;
         rf_d  = head_d;
      end else if (wb_live && !wb_stall) begin
         rf_we = 1'b1;
      end
   end

   // Scoreboard next state: issue set overrides a same-cycle commit clear.
   always_comb begin
      busy_nxt = busy;
      if (pop && head_wn != 5'd0) busy_nxt[head_wn] = 1'b0;
      if (iss_valid && iss_wn != 5'd0) busy_nxt[iss_wn] = 1'b1;
   end

   assign busy_all = {busy, 1'b0};
   assign haz_a    = busy_all[rna];
   assign haz_b    = busy_all[rnb];
   assign haz_w    = busy_all[rnw];
   assign idle     = fempty && (busy == '0);

   // FIFO payload storage; validity is tracked by cnt so no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fwn[wp] <= lu_wn;
         fd[wp]  <= lu_d;
      end
   end

   // FIFO pointers/count, head age and busy bits.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rp   <= '0;
         wp   <= '0;
         cnt  <= '0;
         age  <= '0;
         busy <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
         if (pop || fempty)            age <= '0;
         else if (age != 4'(STARVE))   age <= age + 4'd1;
         busy <= busy_nxt;
      end
   end
endmodule
